reducao_media: RTL and testbench
================================

REDUCAO_MEDIA -- requirements
Module: reducao_media

Interface
REQ-001 SHALL have parameter LARGURA_ORIG, default 160, source image width in pixels.
REQ-002 SHALL have parameter ALTURA_ORIG, default 120, source image height in pixels.
REQ-003 clk  input  1  clock; all state SHALL change on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a frame; sampled only in IDLE.
REQ-006 zoom_select  input  2  01 = factor 2, 10 = factor 4, 00/11 = factor 1.
REQ-007 pixel_in  input  8  source memory read data, valid one cycle after rom_addr.
REQ-008 rom_addr  output  15  source read address, registered.
REQ-009 ram_addr  output  19  destination write address, registered.
REQ-010 wren  output  1  destination write enable, registered.
REQ-011 pixel_out  output  8  destination write data, registered.
REQ-012 busy  output  1  high in READ and DRAIN.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL downscale by block averaging: each f x f source block maps to one output pixel; output size (LARGURA_ORIG/f) x (ALTURA_ORIG/f).
REQ-015 SHALL capture f from zoom_select on the edge where start is sampled in IDLE; zoom_select changes while not in IDLE SHALL be ignored.
REQ-016 States: IDLE, READ, DRAIN, FLUSH, FINAL; IDLE -> READ on start; READ -> DRAIN after the last source address is issued; DRAIN -> FLUSH -> FINAL -> IDLE unconditionally, one cycle each.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 Output pixels SHALL be produced in raster order (ox fastest, then oy); within a block, source pixels SHALL be read row-major (bx fastest, then by).
REQ-019 rom_addr SHALL equal (oy*f+by)*LARGURA_ORIG + (ox*f+bx), one new address per cycle in READ with no gaps, first address 0 in the first READ cycle.
REQ-020 rom_addr SHALL hold its last value outside READ.
REQ-021 A 12-bit accumulator SHALL sum the f*f data words of a block; a one-cycle-delayed valid flag SHALL qualify pixel_in.
REQ-022 On the edge sampling a block's last datum: pixel_out <= (acc + pixel_in) >> log2(f*f) (shift 0/2/4, truncation); wren <= 1; ram_addr <= oy*(LARGURA_ORIG/f) + ox; accumulator cleared so the next block's first datum, arriving the following cycle, is accumulated without a stall.
REQ-023 wren SHALL be high exactly one cycle per output pixel and low otherwise.
REQ-024 Latency: with start sampled in cycle 0, first address in cycle 1, first wren in cycle f*f+2.
REQ-025 Throughput: one source pixel per cycle; last address in cycle LARGURA_ORIG*ALTURA_ORIG, last wren in that cycle +2 (FLUSH), done in that cycle +3 (FINAL), independent of f.
REQ-026 Counter wrap: bx wraps at f-1 to by; by wraps at f-1 to ox; ox wraps at LARGURA_ORIG/f-1 to oy; last block = (ox, oy) at (LARGURA_ORIG/f-1, ALTURA_ORIG/f-1).
REQ-027 done SHALL be high only in FINAL; busy SHALL be low in IDLE, FLUSH and FINAL.

Reset
REQ-028 On rst: state IDLE; all counters, accumulator and valid flag 0; rom_addr 0, ram_addr 0, pixel_out 0, wren 0, busy 0, done 0; f = 1.
REQ-029 rst mid-frame SHALL abort immediately with no further write; a subsequent start SHALL run a complete frame from address 0.

Verification
REQ-030 f=1, source memory returns addr[7:0] -> 19200 writes, ram_addr n carries n[7:0], last wren cycle 19202, done cycle 19203.
REQ-031 f=2, constant source 200 -> 4800 writes all 200, ram_addr 0..4799 in order, first wren cycle 6.
REQ-032 f=4, each block values 0..15 row-major -> every pixel_out 7 (120>>4); f=2 block {1,1,1,2} -> 1 (truncation).
REQ-033 rst asserted after the 100th write -> wren/busy/done 0 next cycle, state IDLE; new start with f=4 -> 1200 writes, last ram_addr 1199.
REQ-034 start and zoom_select toggled while busy -> no restart, factor unchanged; zoom_select=11 -> factor 1 behaviour.
REQ-035 Back-to-back frames: start asserted in the cycle after done -> second frame identical to the first, no missing or extra wren.

Source files
------------

// File: rtl/reducao_media_if.sv
// Bus between the frame downscaler and its source/destination memories.
// The testbench or host holds the master side.
interface reducao_media_if;
  logic        start;
  logic [1:0]  zoom_select;
  logic [7:0]  pixel_in;
  logic [14:0] rom_addr;
  logic [18:0] ram_addr;
  logic        wren;
  logic [7:0]  pixel_out;
  logic        busy;
  logic        done;

  modport master (
    output start, zoom_select, pixel_in,
    input  rom_addr, ram_addr, wren, pixel_out, busy, done
  );

  modport slave (
    input  start, zoom_select, pixel_in,
    output rom_addr, ram_addr, wren, pixel_out, busy, done
  );
endinterface

// File: rtl/reducao_media.sv
// Block-average image downscaler: streams one source pixel per cycle and
// writes one averaged pixel per f x f block, for f = 1, 2 or 4.
module reducao_media #(
  parameter int LARGURA_ORIG = 160,
  parameter int ALTURA_ORIG  = 120
) (
  input logic             clk,
  input logic             rst,
  reducao_media_if.slave  bus
);

  localparam int OXW = (LARGURA_ORIG > 1) ? $clog2(LARGURA_ORIG) : 1;
  localparam int OYW = (ALTURA_ORIG > 1) ? $clog2(ALTURA_ORIG) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    FLUSH = 3'd3,
    FINAL = 3'd4
  } state_t;

  // The factor is held as log2(f): 0, 1 or 2.
  function automatic logic [1:0] log2f(input logic [1:0] zs);
    case (zs)
      2'b01:   log2f = 2'd1;
      2'b10:   log2f = 2'd2;
      default: log2f = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] fm1(input logic [1:0] lf);
    case (lf)
      2'd1:    fm1 = 2'd1;
      2'd2:    fm1 = 2'd3;
      default: fm1 = 2'd0;
    endcase
  endfunction

  function automatic logic [OXW-1:0] ox_last(input logic [1:0] lf);
    case (lf)
      2'd1:    ox_last = OXW'(LARGURA_ORIG / 2 - 1);
      2'd2:    ox_last = OXW'(LARGURA_ORIG / 4 - 1);
      default: ox_last = OXW'(LARGURA_ORIG - 1);
    endcase
  endfunction

  function automatic logic [OYW-1:0] oy_last(input logic [1:0] lf);
    case (lf)
      2'd1:    oy_last = OYW'(ALTURA_ORIG / 2 - 1);
      2'd2:    oy_last = OYW'(ALTURA_ORIG / 4 - 1);
      default: oy_last = OYW'(ALTURA_ORIG - 1);
    endcase
  endfunction

  // Address increments: next row inside a block, and jump back up to the
  // top-left of the block to the right (a modulo-2^15 subtraction).
  function automatic logic [14:0] row_step(input logic [1:0] lf);
    case (lf)
      2'd1:    row_step = 15'(LARGURA_ORIG - 1);
      2'd2:    row_step = 15'(LARGURA_ORIG - 3);
      default: row_step = 15'd1;
    endcase
  endfunction

  function automatic logic [14:0] blk_step(input logic [1:0] lf);
    case (lf)
      2'd1:    blk_step = 15'(1 - LARGURA_ORIG);
      2'd2:    blk_step = 15'(1 - 3 * LARGURA_ORIG);
      default: blk_step = 15'd1;
    endcase
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    lf_r, bx_r, by_r;
  logic [OXW-1:0] ox_r;
  logic [OYW-1:0] oy_r;
  logic [18:0]   blk_r, vaddr_r, ram_addr_r;
  logic [14:0]   rom_addr_r;
  logic          v_r, vlast_r, wren_r, busy_r, done_r;
  logic [11:0]   acc_r, sum_s;
  logic [7:0]    pixel_out_r;
  logic          blk_end_s, last_s;

  assign blk_end_s = (bx_r == fm1(lf_r)) && (by_r == fm1(lf_r));
  assign last_s    = blk_end_s && (ox_r == ox_last(lf_r)) && (oy_r == oy_last(lf_r));
  assign sum_s     = acc_r + {4'd0, bus.pixel_in};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.start) state_s = READ; else state_s = IDLE;
      READ:    if (last_s) state_s = DRAIN; else state_s = READ;
      DRAIN:   state_s = FLUSH;
      FLUSH:   state_s = FINAL;
      FINAL:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Source address generator walking blocks in raster order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lf_r       <= 2'd0;
      bx_r       <= 2'd0;
      by_r       <= 2'd0;
      ox_r       <= '0;
      oy_r       <= '0;
      blk_r      <= 19'd0;
      rom_addr_r <= 15'd0;
    end else if (state_r == IDLE && bus.start) begin
      lf_r       <= log2f(bus.zoom_select);
      bx_r       <= 2'd0;
      by_r       <= 2'd0;
      ox_r       <= '0;
      oy_r       <= '0;
      blk_r      <= 19'd0;
      rom_addr_r <= 15'd0;
    end else if (state_r == READ && !last_s) begin
      if (bx_r != fm1(lf_r)) begin
        bx_r       <= bx_r + 2'd1;
        rom_addr_r <= rom_addr_r + 15'd1;
      end else begin
        bx_r <= 2'd0;
        if (by_r != fm1(lf_r)) begin
          by_r       <= by_r + 2'd1;
          rom_addr_r <= rom_addr_r + row_step(lf_r);
        end else begin
          by_r  <= 2'd0;
          blk_r <= blk_r + 19'd1;
          if (ox_r != ox_last(lf_r)) begin
            ox_r       <= ox_r + OXW'(1);
            rom_addr_r <= rom_addr_r + blk_step(lf_r);
          end else begin
            // Right edge: the next row of blocks starts at the next address.
            ox_r       <= '0;
            oy_r       <= oy_r + OYW'(1);
            rom_addr_r <= rom_addr_r + 15'd1;
          end
        end
      end
    end
  end

  // Data path: tags trail the address by one cycle to line up with pixel_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r         <= 1'b0;
      vlast_r     <= 1'b0;
      vaddr_r     <= 19'd0;
      acc_r       <= 12'd0;
      wren_r      <= 1'b0;
      ram_addr_r  <= 19'd0;
      pixel_out_r <= 8'd0;
    end else begin
      v_r     <= (state_r == READ);
      vlast_r <= blk_end_s;
      vaddr_r <= blk_r;
      if (v_r && vlast_r) begin
        pixel_out_r <= 8'(sum_s >> {lf_r, 1'b0});
        ram_addr_r  <= vaddr_r;
        wren_r      <= 1'b1;
        acc_r       <= 12'd0;
      end else if (v_r) begin
        acc_r  <= sum_s;
        wren_r <= 1'b0;
      end else begin
        wren_r <= 1'b0;
      end
    end
  end

  // Status flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == READ) || (state_s == DRAIN);
      done_r <= (state_s == FINAL);
    end
  end

  assign bus.rom_addr  = rom_addr_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.wren      = wren_r;
  assign bus.pixel_out = pixel_out_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_reducao_media.sv
// Self-checking bench for reducao_media on a reduced 48x32 frame, against a
// block-average reference model computed straight from the source image.
module tb_reducao_media;
  localparam int W = 48;
  localparam int H = 32;
  localparam int N = W * H;
  localparam int M_ADDR = 0, M_CONST = 1, M_BLOCK = 2, M_TRUNC = 3, M_RAND = 4;

  typedef struct {
    logic [1:0] zoom;
    int         mode;
    int         f;
    int         writes;
    int         first;
    int         cval;
  } vec_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reducao_media_if bus();

  reducao_media #(.LARGURA_ORIG(W), .ALTURA_ORIG(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] src [N];
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int exp_addr_q[$];
  wr_t exp_wr_q[$];
  wr_t got_wr_q[$];
  vec_t vec[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous source memory: data one cycle after the address.
  always @(posedge clk)
    bus.pixel_in <= (int'(bus.rom_addr) < N) ? src[int'(bus.rom_addr)] : 8'd0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic fill_src(input int mode);
    for (int a = 0; a < N; a++) begin
      case (mode)
        M_ADDR:  src[a] = 8'(a);
        M_CONST: src[a] = 8'd200;
        M_BLOCK: src[a] = 8'(((a / W) % 4) * 4 + (a % W) % 4);
        M_TRUNC: src[a] = (((a / W) % 2 == 1) && ((a % W) % 2 == 1)) ? 8'd2 : 8'd1;
        default: src[a] = 8'($urandom);
      endcase
    end
  endtask

  task automatic build_model(input int f);
    exp_addr_q.delete();
    exp_wr_q.delete();
    for (int oy = 0; oy < H / f; oy++)
      for (int ox = 0; ox < W / f; ox++) begin
        int sum = 0;
        for (int by = 0; by < f; by++)
          for (int bx = 0; bx < f; bx++) begin
            int a = (oy * f + by) * W + ox * f + bx;
            exp_addr_q.push_back(a);
            sum += int'(src[a]);
          end
        exp_wr_q.push_back('{oy * (W / f) + ox, sum / (f * f)});
      end
  endtask

  task automatic run_frame(input logic [1:0] z, input int f, input int mode,
                           input int exp_writes, input int exp_first,
                           input int exp_const, input bit toggle, input string tag);
    int first_rel = -1, last_rel = -1, done_rel = -1;
    int addr_err = 0, busy_err = 0, pix_err = 0, const_err = 0;
    fill_src(mode);
    build_model(f);
    got_wr_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.zoom_select = z;
    for (int k = 1; k <= N + 20 && done_rel < 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k <= N) begin
        if (int'(bus.rom_addr) != exp_addr_q[k-1]) addr_err++;
      end else if (int'(bus.rom_addr) != exp_addr_q[N-1]) addr_err++;
      if (bus.busy !== (k <= N + 1)) busy_err++;
      if (bus.wren === 1'b1) begin
        got_wr_q.push_back('{int'(bus.ram_addr), int'(bus.pixel_out)});
        if (first_rel < 0) first_rel = k;
        last_rel = k;
      end
      if (bus.done === 1'b1) done_rel = k;
      if (toggle && k >= 3 && k < 100) begin
        bus.start = (k % 3 == 0);
        bus.zoom_select = 2'($urandom);
      end else if (toggle && k == 100) begin
        bus.start = 1'b0;
        bus.zoom_select = z;
      end
    end
    for (int i = 0; i < got_wr_q.size(); i++) begin
      if (i >= exp_wr_q.size()) pix_err++;
      else if (got_wr_q[i].addr != exp_wr_q[i].addr || got_wr_q[i].data != exp_wr_q[i].data)
        pix_err++;
      if (exp_const >= 0 && got_wr_q[i].data != exp_const) const_err++;
    end
    chk($sformatf("%s write count", tag), got_wr_q.size(), exp_writes);
    chk($sformatf("%s first wren cycle", tag), first_rel, exp_first);
    chk($sformatf("%s last wren cycle", tag), last_rel, N + 2);
    chk($sformatf("%s done cycle", tag), done_rel, N + 3);
    chk($sformatf("%s rom_addr errors", tag), addr_err, 0);
    chk($sformatf("%s busy errors", tag), busy_err, 0);
    chk($sformatf("%s pixel/addr errors", tag), pix_err, 0);
    chk($sformatf("%s last ram_addr", tag),
        (got_wr_q.size() > 0) ? got_wr_q[got_wr_q.size()-1].addr : -1, exp_writes - 1);
    if (exp_const >= 0) chk($sformatf("%s constant value errors", tag), const_err, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk($sformatf("%s wren", tag), bus.wren, 0);
    chk($sformatf("%s busy", tag), bus.busy, 0);
    chk($sformatf("%s done", tag), bus.done, 0);
    chk($sformatf("%s rom_addr", tag), bus.rom_addr, 0);
    chk($sformatf("%s ram_addr", tag), bus.ram_addr, 0);
    chk($sformatf("%s pixel_out", tag), bus.pixel_out, 0);
  endtask

  initial begin
    int wcnt, stray;
    vec[0] = '{2'b00, M_ADDR,  1, N,      3,  -1};
    vec[1] = '{2'b01, M_CONST, 2, N / 4,  6,  200};
    vec[2] = '{2'b10, M_BLOCK, 4, N / 16, 18, 7};
    vec[3] = '{2'b01, M_TRUNC, 2, N / 4,  6,  1};
    vec[4] = '{2'b11, M_RAND,  1, N,      3,  -1};
    vec[5] = '{2'b10, M_RAND,  4, N / 16, 18, -1};
    vec[6] = '{2'b01, M_RAND,  2, N / 4,  6,  -1};
    vec[7] = '{2'b01, M_CONST, 2, N / 4,  6,  200};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.zoom_select = 2'b00;
    for (int a = 0; a < N; a++) src[a] = 8'd0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Frames run back to back: each starts the cycle after the previous done.
    for (int i = 0; i < 8; i++)
      run_frame(vec[i].zoom, vec[i].f, vec[i].mode, vec[i].writes, vec[i].first,
                vec[i].cval, 1'b0, $sformatf("vec%0d", i));

    run_frame(2'b01, 2, M_CONST, N / 4, 6, 200, 1'b0, "repeat");
    run_frame(2'b01, 2, M_RAND, N / 4, 6, -1, 1'b1, "toggle");

    // Abort mid-frame after the 100th write.
    fill_src(M_RAND);
    @(negedge clk);
    bus.start = 1'b1;
    bus.zoom_select = 2'b01;
    wcnt = 0;
    for (int k = 1; k <= N && wcnt < 100; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.wren === 1'b1) wcnt++;
    end
    chk("writes before abort", wcnt, 100);
    rst = 1'b1;
    #1;
    chk_idle_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.wren !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
    end
    chk("activity after abort", stray, 0);
    run_frame(2'b10, 4, M_RAND, N / 16, 18, -1, 1'b0, "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
